vga_timing_gen: RTL

- Master raster timing source for the display pipeline; drives the producer side of the timing interface (timing_if.out): hcount, vcount, hsync, hblnk, vsync, vblnk.
- All background, sprite and text draw stages consume this as timing_if.in, directly or through vga_if.
- Free-running horizontal/vertical counter pair with a pixel-enable, so one block serves both a native pixel clock and a faster system clock.
- Also outputs a one-cycle frame-start pulse for game-logic frame ticks.

---
 rtl/vga_timing_gen_if.sv | 13 +
 rtl/vga_timing_gen.sv | 104 ++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle shared by the timing generator and every draw stage.
// The generator drives it through the out modport; consumers use the in modport.
interface timing_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        hblnk;
  logic        vsync;
  logic        vblnk;

  modport out (output hcount, vcount, hsync, hblnk, vsync, vblnk);
  modport in  (input  hcount, vcount, hsync, hblnk, vsync, vblnk);
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running raster counter pair with pixel enable. Every output is a flop, and the
// strobes are decoded from the next counts so they line up with the counts they describe.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pix_en,
  timing_if.out        tim,
  output logic         frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_C     = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_C     = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_FRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_LAST = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] V_SYNC_FRST = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_LAST = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Counters are 11 bits wide, so totals above 2048 cannot be represented.
  if (H_TOTAL > 2048 || V_TOTAL > 2048 ||
      H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_param_check
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q,  hsync_d;
  logic        hblnk_q,  hblnk_d;
  logic        vsync_q,  vsync_d;
  logic        vblnk_q,  vblnk_d;
  logic        frame_start_q, frame_start_d;

  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hsync_d       = hsync_q;
    hblnk_d       = hblnk_q;
    vsync_d       = vsync_q;
    vblnk_d       = vblnk_q;
    frame_start_d = 1'b0;
    if (pix_en) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        if (vcount_q == V_LAST) begin
          vcount_d      = '0;
          frame_start_d = 1'b1;
        end else begin
          vcount_d = vcount_q + 11'd1;
        end
      end else begin
        hcount_d = hcount_q + 11'd1;
      end
      // Decode from the next counts: strobes and counts change on the same edge.
      hblnk_d = (hcount_d >= H_ACT_C);
      vblnk_d = (vcount_d >= V_ACT_C);
      hsync_d = ((hcount_d >= H_SYNC_FRST) && (hcount_d <= H_SYNC_LAST)) ? SYNC_POL : ~SYNC_POL;
      vsync_d = ((vcount_d >= V_SYNC_FRST) && (vcount_d <= V_SYNC_LAST)) ? SYNC_POL : ~SYNC_POL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= ~SYNC_POL;
      hblnk_q       <= 1'b0;
      vsync_q       <= ~SYNC_POL;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      hblnk_q       <= hblnk_d;
      vsync_q       <= vsync_d;
      vblnk_q       <= vblnk_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign tim.hcount  = hcount_q;
  assign tim.vcount  = vcount_q;
  assign tim.hsync   = hsync_q;
  assign tim.hblnk   = hblnk_q;
  assign tim.vsync   = vsync_q;
  assign tim.vblnk   = vblnk_q;
  assign frame_start = frame_start_q;

endmodule
